// File: rtl/coeff_server.sv
// Double-buffered coefficient store for an 8-filter bank; bank swaps only on a sample strobe.
// Optional macro COEFF_CLEAR_EN: reset sweeps both banks to zero before accepting writes.
module coeff_server #(
    parameter int ADDR_W  = 6,
    parameter int DEPTH   = 64,
    parameter int COEFF_W = 36
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               din_enable,
    input  logic [ADDR_W-1:0]  coeffaddress,
    output logic [COEFF_W-1:0] coeff0,
    output logic [COEFF_W-1:0] coeff1,
    output logic [COEFF_W-1:0] coeff2,
    output logic [COEFF_W-1:0] coeff3,
    output logic [COEFF_W-1:0] coeff4,
    output logic [COEFF_W-1:0] coeff5,
    output logic [COEFF_W-1:0] coeff6,
    output logic [COEFF_W-1:0] coeff7,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [2:0]         wr_filter,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [COEFF_W-1:0] wr_data,
    input  logic               commit,
    output logic               commit_pending,
    output logic               active_bank
);

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_PENDING = 2'd1,
        S_CLEAR   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_active_bank;
    logic               w_wr_ready;
    logic               w_pending;
    logic               w_swap;
    logic [COEFF_W-1:0] r_mem [0:1][0:7][0:DEPTH-1];
    logic [COEFF_W-1:0] r_coeff_p1 [0:7];
`ifdef COEFF_CLEAR_EN
    logic               w_clear;
    logic [ADDR_W-1:0]  r_clr_cnt;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_wr_ready  = 1'b0;
        w_pending   = 1'b0;
        w_swap      = 1'b0;
`ifdef COEFF_CLEAR_EN
        w_clear     = 1'b0;
`endif
        case (r_state)
            S_LOAD: begin
                w_wr_ready = 1'b1;
                if (commit) w_state_nxt = S_PENDING;
            end
            S_PENDING: begin
                // Swap only on a sample boundary so no filter sees a mixed set.
                w_pending = 1'b1;
                if (din_enable) begin
                    w_state_nxt = S_LOAD;
                    w_swap      = 1'b1;
                end
            end
`ifdef COEFF_CLEAR_EN
            S_CLEAR: begin
                w_clear = 1'b1;
                if (r_clr_cnt == ADDR_W'(DEPTH - 1)) w_state_nxt = S_LOAD;
            end
`endif
            default: w_state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
`ifdef COEFF_CLEAR_EN
            r_state <= S_CLEAR;
`else
            r_state <= S_LOAD;
`endif
            r_active_bank <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_swap) r_active_bank <= ~r_active_bank;
        end
    end

`ifdef COEFF_CLEAR_EN
    always_ff @(posedge clock) begin
        if (reset)        r_clr_cnt <= '0;
        else if (w_clear) r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
    end
`endif

    // Stage p0 -> memory: host writes land only in the shadow bank.
    always_ff @(posedge clock) begin
`ifdef COEFF_CLEAR_EN
        if (w_clear) begin
            for (int b = 0; b < 2; b++)
                for (int f = 0; f < 8; f++)
                    r_mem[b][f][r_clr_cnt] <= '0;
        end else
`endif
        if (wr_valid && w_wr_ready)
            r_mem[~r_active_bank][wr_filter][wr_addr] <= wr_data;
    end

    // Stage p1: registered read; bank select is the pre-edge value.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int n = 0; n < 8; n++) r_coeff_p1[n] <= '0;
`ifdef COEFF_CLEAR_EN
        end else if (w_clear) begin
            for (int n = 0; n < 8; n++) r_coeff_p1[n] <= '0;
`endif
        end else begin
            for (int n = 0; n < 8; n++)
                r_coeff_p1[n] <= r_mem[r_active_bank][n][coeffaddress];
        end
    end

    assign coeff0         = r_coeff_p1[0];
    assign coeff1         = r_coeff_p1[1];
    assign coeff2         = r_coeff_p1[2];
    assign coeff3         = r_coeff_p1[3];
    assign coeff4         = r_coeff_p1[4];
    assign coeff5         = r_coeff_p1[5];
    assign coeff6         = r_coeff_p1[6];
    assign coeff7         = r_coeff_p1[7];
    assign wr_ready       = w_wr_ready;
    assign commit_pending = w_pending;
    assign active_bank    = r_active_bank;

endmodule
